cpu_memory: RTL

CPU_MEMORY -- requirements
Module: cpu_memory

---
 rtl/cpu_pkg.sv | 15 +
 rtl/mem_array.sv | 36 +++
 rtl/cpu_memory.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_memory block.
//   mem_state_e : controller states (CLEAR zeroes the array, IDLE serves requests)
//   MEM_ADDR_W  : default request address width
//   MEM_DATA_W  : default data width
package cpu_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } mem_state_e;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 16;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage with byte-enable write and registered read.
// The storage is never reset; the owner zeroes it by writing.
// Ports:
//   clk   : clock
//   we    : write strobe, bytes selected by be are updated at the edge
//   re    : read strobe, rdata captures mem[addr] at the edge and holds otherwise
//   addr  : word address (caller guarantees addr < DEPTH when we/re is high)
//   wdata : write data
//   be    : byte enables, bit i covers wdata[8i+7:8i]
//   rdata : registered read data
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_memory.sv
// Request/response memory with a power-on (and on-demand) clear sequence.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   clr                  : pulse in IDLE restarts the clear of the whole array
//   req_valid/req_ready  : request handshake
//   req_we, req_addr     : 1 = write / 0 = read, word address
//   req_wdata, req_be    : write data and byte enables
//   rsp_valid/rsp_ready  : response handshake (one-entry response buffer)
//   rsp_rdata, rsp_err   : read data (0 for writes/errors), out-of-range flag
//   init_busy            : clear sequence in progress
module cpu_memory
  import cpu_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_busy
);

  localparam int BE_W = DATA_W/8;

  mem_state_e        state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_last;
  logic              in_range;
  logic              accept;
  logic              rd_sel_p1;

  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;
  logic [BE_W-1:0]   arr_be;

  assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));
  // Extra bit so DEPTH == 2**ADDR_W is representable in the compare.
  assign in_range = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
  assign accept   = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    init_busy = 1'b0;
    req_ready = 1'b0;
    case (state)
      CLEAR: begin
        init_busy = 1'b1;
        if (clr_last) state_nxt = IDLE;
      end
      IDLE: begin
        req_ready = !rsp_valid || rsp_ready;
        if (clr) state_nxt = CLEAR;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              clr_cnt <= '0;
    else if (state == CLEAR && !clr_last)    clr_cnt <= clr_cnt + 1'b1;
    else                                     clr_cnt <= '0;
  end

  // The clear owns the array port in CLEAR; requests own it in IDLE.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = req_addr;
    arr_wdata = req_wdata;
    arr_be    = req_be;
    if (state == CLEAR) begin
      arr_we    = 1'b1;
      arr_addr  = clr_cnt;
      arr_wdata = '0;
      arr_be    = '1;
    end else begin
      arr_we = accept && req_we  && in_range;
      arr_re = accept && !req_we && in_range;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .be    (arr_be),
    .rdata (arr_rdata)
  );

  // ---- response stage (_p1): one cycle after accept ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_sel_p1 <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= !in_range;
      rd_sel_p1 <= !req_we && in_range;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_sel_p1 <= 1'b0;
    end
  end

  // The array read register only moves on a read accept, so the selected
  // data holds while the response is stalled; writes/errors report zero.
  assign rsp_rdata = rd_sel_p1 ? arr_rdata : '0;

`ifndef SYNTHESIS
  a_req_known: assert property (@(posedge clk) disable iff (!rst_n)
    req_valid |-> !$isunknown({req_addr, req_we, req_be}))
    else $error("request control fields unknown while req_valid");

  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (req_valid && !req_ready) |=> $stable({req_addr, req_we, req_be, req_wdata}))
    else $error("request fields changed while stalled");
`endif

endmodule
